tx_framer: RTL and testbench
============================

// Module: tx_framer
// PURPOSE
//   Transmit framing stage that sits directly upstream of the byte-striping block; its out_byte drives the striper's fromMux.
//   Takes payload bytes over a valid/ready handshake and wraps each packet as start symbol, data, PAD fill and END.
//   Frame length (start+data+PAD+END) is always a multiple of 4, so END lands in lane 3 of the striper.
//   Emits IDL between packets and inserts a COM,SKP,SKP,SKP ordered set periodically between packets.
// PARAMETERS
//   SKP_INTERVAL  1180  cycles between SKP ordered-set requests (>=8)
//   CNT_W         11    width of SKP interval counter (must hold SKP_INTERVAL-1)
// PORTS
//   clk         in   1  rising-edge clock
//   reset       in   1  synchronous, active-high reset
//   in_valid    in   1  payload byte available
//   in_data     in   8  payload byte
//   in_last     in   1  qualifies in_data as last byte of packet
//   in_sdp      in   1  packet type, sampled with first byte: 1=SDP start, 0=STP start
//   in_ready    out  1  byte accepted when in_valid&in_ready at posedge
//   out_byte    out  8  symbol to striper, one per cycle
//   out_k       out  1  1=control symbol (STP/SDP/END/PAD/IDL/COM/SKP), 0=data byte
//   frame_act   out  1  1 from start symbol through END inclusive
//   underrun    out  1  one-cycle pulse when PAD is emitted for a missing mid-packet byte
// BEHAVIOUR
//   Codes: COM=BC PAD=F7 SKP=1C STP=FB SDP=5C END=FD IDL=7C.
//   Reset: state IDLE, out_byte=IDL, out_k=1, in_ready=0, frame_act=0, underrun=0, pos=0, skp cnt=0, skp_pend=0.
//   All outputs are registered; in_ready is decoded from the registered state: 1 only in DATA.
//   Latency: a byte accepted at edge n appears on out_byte after edge n (one cycle).
//   pos[1:0]: slot counter of the current frame; wraps 3->0.
//   States:
//     IDLE:  if skp_pend -> emit COM, go SKP1. Else if in_valid -> emit STP/SDP per in_sdp, out_k=1, pos=1, go DATA.
//            Otherwise emit IDL.
//            The first byte is not consumed in IDLE.
//     SKP1..SKP3:  emit SKP, out_k=1.
//            At SKP3, clear skp_pend and go IDLE.
//            A SKP set is never interrupted and never inserted inside a frame.
//     DATA:  if in_valid -> emit in_data, out_k=0, pos++.
//              If in_last and new pos==3, go END; if in_last and new pos!=3, go PAD.
//            If !in_valid -> emit PAD, out_k=1, pos++, pulse underrun; stay in DATA.
//     PAD:   emit PAD, pos++.
//            Go END when new pos==3.
//     END:   emit END, out_k=1, pos=0, go IDLE.
//            frame_act drops on the following cycle.
//   SKP timer: runs every cycle in every state.
//     At SKP_INTERVAL-1 it wraps to 0 and sets skp_pend.
//     A second expiry while skp_pend is already set is absorbed; only one set is sent.
//   Priority in IDLE: a pending SKP wins over in_valid; the packet starts immediately after SKP3.
//   Payload bytes equal to control codes are passed through with out_k=0 and are not interpreted.
//   Minimum packet is 1 data byte; in_last with the first data byte is legal.
//   Reset mid-frame or mid-SKP: the partial frame is dropped with no END, and IDL is output on the next cycle.
// TESTING
//   1) Reset, no in_valid -> out_byte=7C, out_k=1 every cycle; in_ready=0.
//   2) STP packet of 2 bytes {11,22} -> out_byte FB,11,22,FD (4 bytes); END in slot 3; in_ready high exactly 2 cycles.
//   3) SDP packet of 1 byte {AA} -> 5C,AA,F7,FD; packet of 3 bytes {01,02,03} -> FB,01,02,03,F7,F7,F7,FD.
//   4) in_valid drops for 1 cycle mid-packet -> one F7 with out_k=1 is inserted; underrun pulses once; END still lands at pos 3.
//   5) SKP_INTERVAL=8 with skp_pend set while in_valid waits in IDLE -> BC,1C,1C,1C, then the start symbol.
//      A timer expiry mid-frame defers the SKP set until after END.
//   6) Assert reset during the DATA state of a 6-byte packet -> next cycle out_byte=7C, frame_act=0, in_ready=0.
//      The following packet frames correctly from pos 0.

Source files
------------

// File: rtl/tx_framer.sv
// tx_framer: wraps payload packets as STP/SDP + data + PAD fill + END so the
// frame length is a multiple of 4 and END falls in striper lane 3. IDL fills
// the gaps between packets, and a COM,SKP,SKP,SKP ordered set is inserted
// periodically, always between frames.
module tx_framer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int CNT_W        = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  input  logic       in_sdp,
  output logic       in_ready,
  output logic [7:0] out_byte,
  output logic       out_k,
  output logic       frame_act,
  output logic       underrun
);

  localparam logic [7:0] C_COM = 8'hBC;
  localparam logic [7:0] C_PAD = 8'hF7;
  localparam logic [7:0] C_SKP = 8'h1C;
  localparam logic [7:0] C_STP = 8'hFB;
  localparam logic [7:0] C_SDP = 8'h5C;
  localparam logic [7:0] C_END = 8'hFD;
  localparam logic [7:0] C_IDL = 8'h7C;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SKP_INTERVAL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SKP1,
    S_SKP2,
    S_SKP3,
    S_DATA,
    S_PAD,
    S_END
  } state_t;

  state_t           r_state;
  logic [1:0]       r_pos;
  logic [CNT_W-1:0] r_cnt;
  logic             r_skp_pend;
  logic [7:0]       r_out_byte;
  logic             r_out_k;
  logic             r_frame_act;
  logic             r_underrun;

  logic             w_expire;
  logic [1:0]       w_pos_nx;

  assign w_expire  = (r_cnt == CNT_MAX);
  assign w_pos_nx  = r_pos + 2'd1;

  assign in_ready  = (r_state == S_DATA);
  assign out_byte  = r_out_byte;
  assign out_k     = r_out_k;
  assign frame_act = r_frame_act;
  assign underrun  = r_underrun;

  // Free-running SKP interval timer; runs in every state.
  always_ff @(posedge clk) begin
    if (reset)         r_cnt <= '0;
    else if (w_expire) r_cnt <= '0;
    else               r_cnt <= r_cnt + 1'b1;
  end

  // Framing FSM with registered symbol outputs and the pending-SKP flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_pos       <= 2'd0;
      r_skp_pend  <= 1'b0;
      r_out_byte  <= C_IDL;
      r_out_k     <= 1'b1;
      r_frame_act <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      // Expiry sets the flag (a repeat expiry is absorbed); SKP3 retires it.
      r_skp_pend <= w_expire | (r_skp_pend & (r_state != S_SKP3));
      r_underrun <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_out_k <= 1'b1;
          if (r_skp_pend) begin
            r_out_byte  <= C_COM;
            r_frame_act <= 1'b0;
            r_state     <= S_SKP1;
          end else if (in_valid) begin
            // Start symbol only; the first byte stays on the bus for DATA.
            r_out_byte  <= in_sdp ? C_SDP : C_STP;
            r_frame_act <= 1'b1;
            r_pos       <= 2'd1;
            r_state     <= S_DATA;
          end else begin
            r_out_byte  <= C_IDL;
            r_frame_act <= 1'b0;
          end
        end
        S_SKP1, S_SKP2, S_SKP3: begin
          r_out_byte  <= C_SKP;
          r_out_k     <= 1'b1;
          r_frame_act <= 1'b0;
          case (r_state)
            S_SKP1:  r_state <= S_SKP2;
            S_SKP2:  r_state <= S_SKP3;
            default: r_state <= S_IDLE;
          endcase
        end
        S_DATA: begin
          r_frame_act <= 1'b1;
          r_pos       <= w_pos_nx;
          if (in_valid) begin
            // Payload is passed through untouched, even if it looks like a code.
            r_out_byte <= in_data;
            r_out_k    <= 1'b0;
            if (in_last) r_state <= (w_pos_nx == 2'd3) ? S_END : S_PAD;
          end else begin
            // Missing mid-packet byte: fill the slot and flag it.
            r_out_byte <= C_PAD;
            r_out_k    <= 1'b1;
            r_underrun <= 1'b1;
          end
        end
        S_PAD: begin
          r_out_byte  <= C_PAD;
          r_out_k     <= 1'b1;
          r_frame_act <= 1'b1;
          r_pos       <= w_pos_nx;
          if (w_pos_nx == 2'd3) r_state <= S_END;
        end
        S_END: begin
          r_out_byte  <= C_END;
          r_out_k     <= 1'b1;
          r_frame_act <= 1'b1;
          r_pos       <= 2'd0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_out_byte  <= C_IDL;
          r_out_k     <= 1'b1;
          r_frame_act <= 1'b0;
          r_pos       <= 2'd0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_framer.sv
// tb_tx_framer: table-driven packet vectors plus hand-written reset and SKP
// sequences. Expected symbols are queued as stimulus is driven and popped as
// each output symbol appears.
module tb_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default SKP interval (never expires during this bench's A traffic)
  logic       reset, in_valid, in_last, in_sdp, in_ready, out_k, frame_act, underrun;
  logic [7:0] in_data, out_byte;
  // DUT B: short SKP interval
  logic       b_reset, b_in_valid, b_in_last, b_in_sdp, b_in_ready, b_out_k, b_frame_act, b_underrun;
  logic [7:0] b_in_data, b_out_byte;

  tx_framer u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_sdp(in_sdp), .in_ready(in_ready), .out_byte(out_byte), .out_k(out_k),
    .frame_act(frame_act), .underrun(underrun)
  );

  tx_framer #(.SKP_INTERVAL(8), .CNT_W(3)) u_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
    .in_sdp(b_in_sdp), .in_ready(b_in_ready), .out_byte(b_out_byte), .out_k(b_out_k),
    .frame_act(b_frame_act), .underrun(b_underrun)
  );

  typedef struct packed {
    logic [7:0] b;
    logic       k;
    logic       fa;
    logic       ur;
  } obs_t;

  typedef struct packed {
    logic        sdp;
    logic [3:0]  len;
    logic [63:0] d;    // byte i at d[8*i +: 8]
    logic [3:0]  gap;  // symbol index where in_valid drops; 15 = none
    logic [3:0]  n;    // expected frame length in symbols
    logic [95:0] e;    // expected symbol j at e[8*j +: 8]
    logic [11:0] k;    // expected out_k for symbol j at k[j]
  } vec_t;

  obs_t qa[$];
  obs_t qb[$];
  vec_t tv[6];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic obs_t ob(logic [7:0] b, logic k, logic fa, logic ur);
    obs_t o;
    o.b = b; o.k = k; o.fa = fa; o.ur = ur;
    return o;
  endfunction

  function automatic vec_t mk(logic sdp, int len, logic [63:0] d, int gap, int n,
                              logic [95:0] e, logic [11:0] k);
    vec_t v;
    v.sdp = sdp; v.len = 4'(len); v.d = d; v.gap = 4'(gap);
    v.n = 4'(n); v.e = e; v.k = k;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step_a(string nm);
    obs_t e;
    @(posedge clk); #1;
    if (qa.size() == 0) begin
      chk({nm, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = qa.pop_front();
      chk(nm, 32'({out_byte, out_k, frame_act, underrun}), 32'(e));
    end
  endtask

  task automatic step_b(string nm);
    obs_t e;
    @(posedge clk); #1;
    if (qb.size() == 0) begin
      chk({nm, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = qb.pop_front();
      chk(nm, 32'({b_out_byte, b_out_k, b_frame_act, b_underrun}), 32'(e));
    end
  endtask

  task automatic apply(int t);
    vec_t v;
    int   di;
    int   rdy;
    v = tv[t]; di = 0; rdy = 0;
    for (int j = 0; j < int'(v.n); j++) begin
      if (j == 0) begin
        in_valid = 1'b1; in_sdp = v.sdp; in_data = v.d[7:0]; in_last = (v.len == 4'd1);
      end else if (di < int'(v.len) && j != int'(v.gap)) begin
        in_valid = 1'b1; in_data = v.d[8*di +: 8]; in_last = (di == int'(v.len) - 1);
        di++;
      end else begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      end
      qa.push_back(ob(v.e[8*j +: 8], v.k[j], 1'b1, (j == int'(v.gap))));
      step_a($sformatf("pkt%0d_sym%0d", t, j));
      if (in_ready) rdy++;
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
    qa.push_back(ob(8'h7C, 1'b1, 1'b0, 1'b0));
    step_a($sformatf("pkt%0d_idle", t));
    chk($sformatf("pkt%0d_ready_cycles", t), 32'(rdy),
        32'(int'(v.len) + ((v.gap != 4'hF) ? 1 : 0)));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; in_sdp = 1'b0;
    b_reset = 1'b1; b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0; b_in_sdp = 1'b0;

    tv[0] = mk(1'b0, 2, 64'h2211,        15, 4, 96'hFD2211FB,         12'h009);
    tv[1] = mk(1'b1, 1, 64'hAA,          15, 4, 96'hFDF7AA5C,         12'h00D);
    tv[2] = mk(1'b0, 3, 64'h030201,      15, 8, 96'hFDF7F7F7030201FB, 12'h0F1);
    tv[3] = mk(1'b0, 1, 64'h33,           1, 4, 96'hFD33F7FB,         12'h00B);
    tv[4] = mk(1'b0, 3, 64'h7CBCFD,      15, 8, 96'hFDF7F7F77CBCFDFB, 12'h0F1);
    tv[5] = mk(1'b0, 6, 64'h605040302010, 15, 8, 96'hFD605040302010FB, 12'h081);

    // Reset state of both instances
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a", 32'({out_byte, out_k, frame_act, underrun, in_ready}), 32'({8'h7C, 4'b1000}));
    chk("rst_b", 32'({b_out_byte, b_out_k, b_frame_act, b_underrun, b_in_ready}), 32'({8'h7C, 4'b1000}));
    reset = 1'b0;

    // Idle line: IDL every cycle, never ready
    for (int i = 0; i < 3; i++) begin
      qa.push_back(ob(8'h7C, 1'b1, 1'b0, 1'b0));
      step_a($sformatf("idle%0d", i));
      chk($sformatf("idle%0d_ready", i), 32'(in_ready), 32'd0);
    end

    // Packet table
    for (int t = 0; t < 6; t++) apply(t);

    // Reset in the middle of a 6-byte packet
    in_valid = 1'b1; in_sdp = 1'b0; in_data = 8'h10; in_last = 1'b0;
    qa.push_back(ob(8'hFB, 1'b1, 1'b1, 1'b0));
    step_a("mr_stp");
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(8'h10 * (i + 1));
      qa.push_back(ob(8'(8'h10 * (i + 1)), 1'b0, 1'b1, 1'b0));
      step_a($sformatf("mr_d%0d", i));
    end
    reset = 1'b1; in_data = 8'h40;
    qa.push_back(ob(8'h7C, 1'b1, 1'b0, 1'b0));
    step_a("mr_reset_out");
    chk("mr_reset_ready", 32'(in_ready), 32'd0);
    reset = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    qa.push_back(ob(8'h7C, 1'b1, 1'b0, 1'b0));
    step_a("mr_after");
    apply(0);

    // SKP sequence on the short-interval instance: expiry at edge 8 while
    // idle, packet waiting from edge 9, second expiry at edge 16 mid-frame.
    b_reset = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      obs_t e;
      b_in_sdp = 1'b0;
      if (k >= 9 && k <= 14) begin
        b_in_valid = 1'b1; b_in_data = 8'hB1; b_in_last = 1'b0;
      end else if (k == 15) begin
        b_in_valid = 1'b1; b_in_data = 8'hB2; b_in_last = 1'b0;
      end else if (k == 16) begin
        b_in_valid = 1'b1; b_in_data = 8'hB3; b_in_last = 1'b1;
      end else begin
        b_in_valid = 1'b0; b_in_data = 8'h00; b_in_last = 1'b0;
      end
      if (k <= 8)                   e = ob(8'h7C, 1'b1, 1'b0, 1'b0);
      else if (k == 9 || k == 21)   e = ob(8'hBC, 1'b1, 1'b0, 1'b0);
      else if (k <= 12 || k >= 22)  e = ob(8'h1C, 1'b1, 1'b0, 1'b0);
      else if (k == 13)             e = ob(8'hFB, 1'b1, 1'b1, 1'b0);
      else if (k == 14)             e = ob(8'hB1, 1'b0, 1'b1, 1'b0);
      else if (k == 15)             e = ob(8'hB2, 1'b0, 1'b1, 1'b0);
      else if (k == 16)             e = ob(8'hB3, 1'b0, 1'b1, 1'b0);
      else if (k <= 19)             e = ob(8'hF7, 1'b1, 1'b1, 1'b0);
      else                          e = ob(8'hFD, 1'b1, 1'b1, 1'b0);
      qb.push_back(e);
      step_b($sformatf("skp_e%0d", k));
      if (k == 12) chk("skp_ready_held", 32'(b_in_ready), 32'd0);
      if (k == 13) chk("skp_ready_data", 32'(b_in_ready), 32'd1);
    end
    b_in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
